// File: rtl/fifo_fwft_pkg.sv
// Shared constants for the canny pipeline: image geometry and the default
// inter-stage FIFO shape so every stage instance agrees.
package fifo_fwft_pkg;

  localparam int IMG_WIDTH        = 720;
  localparam int IMG_HEIGHT       = 540;
  localparam int FIFO_DATA_WIDTH  = 8;
  localparam int FIFO_BUFFER_SIZE = 16;

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO between canny stages: the head word is visible
// on dout whenever empty=0, so the consumer can sample it while popping.
module fifo_fwft
  import fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH        = FIFO_DATA_WIDTH,
  parameter int BUFFER_SIZE       = FIFO_BUFFER_SIZE,
  parameter int ALMOST_FULL_LEVEL = BUFFER_SIZE - 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic                           full,
  output logic                           almost_full,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           empty,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_accept, rd_accept;

  always_comb begin
    full        = (count_q == CW'(BUFFER_SIZE));
    empty       = (count_q == '0);
    almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
    wr_accept   = wr_en && !full;
    rd_accept   = rd_en && !empty;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
    // Simultaneous accepted read and write leave the occupancy unchanged.
    if (wr_accept && !rd_accept) count_d = count_q + CW'(1);
    if (rd_accept && !wr_accept) count_d = count_q - CW'(1);
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only blocks the write in that cycle.
  always_ff @(posedge clock) begin
    if (!reset && wr_accept) mem[wr_ptr_q] <= din;
  end

  assign dout      = empty ? '0 : mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft: stimulus queues expected pops, a negedge
// monitor compares every accepted pop against the queue head.
module tb_fifo_fwft;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din   = '0;
  logic       rd_en = 1'b0;
  logic       full, almost_full, empty, overflow, underflow;
  logic [7:0] dout;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_fwft dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Monitor: a pop happens whenever rd_en is high on a non-empty FIFO.
  always @(negedge clock) begin
    logic [7:0] e;
    if (!reset && rd_en && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop: got %02h, required no pop (scoreboard empty)", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL pop: got %02h, required %02h", dout, e);
        end else begin
          $display("pop %02h ok", dout);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", dout, 0);

    // Three writes, first-word-fall-through latency
    push_wr(8'h11);
    chk("fwft_empty", empty, 0);
    chk("fwft_dout", dout, 8'h11);
    push_wr(8'h22);
    push_wr(8'h33);
    chk("count3", count, 3);
    chk("head_after3", dout, 8'h11);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain3_empty", empty, 1);

    // Fill to full, check almost_full threshold
    for (int i = 0; i < 16; i++) begin
      push_wr(8'(i));
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    chk("full", full, 1);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);

    // Read and write on a full FIFO: read wins, write dropped
    cyc(1'b1, 8'h55, 1'b1);
    chk("rw_full_count", count, 15);
    chk("rw_full_flag", full, 0);
    chk("rw_full_ovf", overflow, 1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain16_empty", empty, 1);

    // Half-full streaming, pointers wrap more than twice
    for (int i = 0; i < 8; i++) push_wr(8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(8'h88 + i));
      cyc(1'b1, 8'(8'h88 + i), 1'b1);
      chk("stream_count", count, 8);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("stream_empty", empty, 1);

    // Underflow on empty read
    chk("unf_clear", underflow, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_set", underflow, 1);
    chk("unf_dout", dout, 0);
    chk("unf_count", count, 0);
    push_wr(8'h7E);
    chk("after_unf_count", count, 1);
    chk("after_unf_dout", dout, 8'h7E);
    cyc(1'b0, 8'h00, 1'b1);
    chk("after_unf_empty", empty, 1);

    // Reset mid-stream discards contents and clears sticky flags
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_rst_count", count, 5);
    reset = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1);
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_unf", underflow, 0);
    push_wr(8'h9C);
    chk("post_rst_dout", dout, 8'h9C);
    chk("post_rst_count", count, 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", empty, 1);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
- Synchronous first-word-fall-through FIFO: the responder end of the pixel-stream handshake used between canny pipeline stages.
- Producer side: wr_en / din / full. Consumer side: rd_en / dout / empty.
- The head word is presented on dout whenever empty=0, so a consumer may sample dout in the same cycle it asserts rd_en.
- One instance sits between each pair of stages (grayscale→gaussian_blur, gaussian_blur→sobel, ...).

Parameters:
- FIFO_DATA_WIDTH, 8, bits per word (one pixel).
- FIFO_BUFFER_SIZE, 16, depth in words; must be a power of two ≥ 2.
- ALMOST_FULL_LEVEL, FIFO_BUFFER_SIZE-2, count at or above which almost_full asserts.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  producer write request.
- din  in  FIFO_DATA_WIDTH  write data.
- full  out  1  no free entry.
- almost_full  out  1  count ≥ ALMOST_FULL_LEVEL.
- rd_en  in  1  consumer pop request.
- dout  out  FIFO_DATA_WIDTH  head word, valid while empty=0.
- empty  out  1  no stored word.
- count  out  $clog2(FIFO_BUFFER_SIZE)+1  words currently stored.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (synchronous, active-high, one clock; overrides every other input that cycle):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
  - Memory contents are not cleared.
  - Reset mid-stream discards all stored words.
- Storage and pointers:
  - Register array of FIFO_BUFFER_SIZE words.
  - wr_ptr and rd_ptr are $clog2(FIFO_BUFFER_SIZE) bits and wrap naturally from FIFO_BUFFER_SIZE-1 to 0.
- Write acceptance:
  - Accepted iff wr_en=1 and full=0 (full as registered at the start of the cycle).
  - mem[wr_ptr] ← din; wr_ptr increments.
- Read acceptance:
  - Accepted iff rd_en=1 and empty=0; rd_ptr increments.
  - The popped word is the value dout showed during that cycle.
- dout is combinational: mem[rd_ptr] when empty=0, else 0.
- Write latency: a word written into an empty FIFO appears on dout, with empty=0, in the cycle after the write edge.
- Count update: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither is.
- Flags are combinational from count:
  - full = (count == FIFO_BUFFER_SIZE).
  - empty = (count == 0).
  - almost_full = (count ≥ ALMOST_FULL_LEVEL).
- Simultaneous read and write:
  - Non-empty, non-full: both accepted.
  - Full: read accepted, write rejected (full is registered); full drops the next cycle.
  - Empty: write accepted, read rejected; underflow sets.
- Error handling:
  - Rejected write: data dropped, no state change except overflow←1.
  - Rejected read: no state change except underflow←1.
  - Both flags hold until reset.
- No internal state machine beyond the pointers and counter.

Decomposition:
- No package types needed; FIFO_BUFFER_SIZE and FIFO_DATA_WIDTH defaults go in the shared canny package alongside the image WIDTH/HEIGHT constants so every stage instance agrees.
- No sub-module: a single flat module.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles → empty=0 from the cycle after the first write; dout=0x11 then; count=3 after the third write.
- Fill 16 words 0x00..0x0F with no reads → full=1 and count=16 after the 16th write; almost_full=1 from count=14; a 17th write of 0xAA is dropped, overflow=1, and a full drain returns 0x00..0x0F in order.
- Full FIFO with rd_en=1 and wr_en=1 (din=0x55) in the same cycle → 0x00 popped, 0x55 dropped, count=15, full=0, overflow=1.
- Half-full (count=8) with continuous rd_en=1 and wr_en=1 for 40 cycles, din incrementing → count stays 8, output is an in-order incrementing sequence, and both pointers wrap at least twice.
- Empty FIFO with rd_en=1 → underflow=1, dout=0, count=0; a later write of 0x7E reads back correctly with no duplication.
- Reset asserted at count=5 → next cycle count=0, empty=1, both sticky flags 0; a subsequent write of 0x9C yields dout=0x9C.
